seq_detector_param: RTL and testbench

Parametrised serial pattern detector: next generation of the fixed 110 detector. Samples a 1-bit stream under an enable qualifier and pulses `match` when the last PAT_W accepted bits equal a run-time loadable pattern. Overlapping or non-overlapping detection is selectable, and an optional saturating match counter is available. Sits between a serial input stage and any control logic consuming detection events.

---
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_detector_param.sv | 90 +++++++++
 tb/tb_seq_detector_param.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detector_param_if                                     |
// | Brief    : Sample/pattern-load/detection bundle for seq_detector_param|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_detector_param_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic             din;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0] pattern;

    modport master (
        output en, din, pat_ld, pat_in,
        input  match, match_cnt, pattern
    );

    modport slave (
        input  en, din, pat_ld, pat_in,
        output match, match_cnt, pattern
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detector_param                                        |
// | Brief    : Run-time loadable serial pattern detector; the saturating |
// |            match counter is built only when SEQDET_CNT_EN is defined.|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_detector_param #(
    parameter int             PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_detector_param_if.slave bus
);
    localparam int               FILL_W     = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t            r_state;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic              r_match;

    logic [PAT_W-1:0]  w_window;
    logic              w_hit;

    assign w_window = {r_hist, bus.din};
    assign w_hit    = bus.en && !bus.pat_ld && (r_state == S_ARMED) && (w_window == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PATTERN;
            r_match <= 1'b0;
        end else if (bus.pat_ld) begin
            r_pat   <= bus.pat_in;
            r_fill  <= '0;
            r_state <= S_FILL;
            r_match <= 1'b0;
        end else if (bus.en) begin
            r_hist  <= w_window[PAT_W-2:0];
            r_match <= w_hit;
            if (w_hit && !OVERLAP) begin
                // Non-overlapping: the window restarts empty after a match.
                r_fill  <= '0;
                r_state <= S_FILL;
            end else if (r_state == S_FILL) begin
                r_fill <= r_fill + FILL_W'(1);
                if (r_fill == c_FILL_MAX - FILL_W'(1)) begin
                    r_state <= S_ARMED;
                end
            end
        end else begin
            r_match <= 1'b0;
        end
    end

    assign bus.match   = r_match;
    assign bus.pattern = r_pat;

`ifdef SEQDET_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = r_cnt;
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_detector_param                                     |
// | Brief    : Three detector variants driven in lockstep and compared   |
// |            against an arithmetic window model.                       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(3), .CNT_W(8)) bus_a ();
    seq_detector_param_if #(.PAT_W(3), .CNT_W(8)) bus_b ();
    seq_detector_param_if #(.PAT_W(3), .CNT_W(2)) bus_c ();

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    int errs   = 0;
    int checks = 0;

    // Model: length of valid bit run, numeric value of last 3 bits, pattern, count.
    int m_len [3];
    int m_win [3];
    int m_pat [3];
    int m_cnt [3];
    int m_mat [3];
    int m_cmax[3] = '{255, 255, 3};
    int m_ovl [3] = '{1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic e, input logic d, input logic l,
                              input logic [2:0] p, input logic r);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_len[k] = 0; m_win[k] = 0; m_pat[k] = 6; m_cnt[k] = 0; m_mat[k] = 0;
            end else if (l) begin
                m_pat[k] = int'(p); m_len[k] = 0; m_mat[k] = 0;
            end else if (e) begin
                m_win[k] = (m_win[k] * 2 + int'(d)) % 8;
                m_len[k] = m_len[k] + 1;
                m_mat[k] = (m_len[k] >= 3 && m_win[k] == m_pat[k]) ? 1 : 0;
                if (m_mat[k] == 1) begin
                    if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                    if (m_ovl[k] == 0) m_len[k] = 0;
                end
            end else begin
                m_mat[k] = 0;
            end
        end
    endtask

    function automatic int exp_cnt(input int k);
`ifdef SEQDET_CNT_EN
        return m_cnt[k];
`else
        return 0 * k;
`endif
    endfunction

    task automatic check_all();
        chk("A_match", {31'b0, bus_a.match},   m_mat[0]);
        chk("A_pat",   {29'b0, bus_a.pattern}, m_pat[0]);
        chk("A_cnt",   {24'b0, bus_a.match_cnt}, exp_cnt(0));
        chk("B_match", {31'b0, bus_b.match},   m_mat[1]);
        chk("B_pat",   {29'b0, bus_b.pattern}, m_pat[1]);
        chk("B_cnt",   {24'b0, bus_b.match_cnt}, exp_cnt(1));
        chk("C_match", {31'b0, bus_c.match},   m_mat[2]);
        chk("C_pat",   {29'b0, bus_c.pattern}, m_pat[2]);
        chk("C_cnt",   {30'b0, bus_c.match_cnt}, exp_cnt(2));
    endtask

    task automatic cyc(input logic e, input logic d, input logic l,
                       input logic [2:0] p, input logic r);
        rst = r;
        bus_a.en = e; bus_a.din = d; bus_a.pat_ld = l; bus_a.pat_in = p;
        bus_b.en = e; bus_b.din = d; bus_b.pat_ld = l; bus_b.pat_in = p;
        bus_c.en = e; bus_c.din = d; bus_c.pat_ld = l; bus_c.pat_in = p;
        @(posedge clk);
        model_edge(e, d, l, p, r);
        #1;
        check_all();
    endtask

    task automatic bit_in(input logic d);
        cyc(1'b1, d, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        logic e, d, l, r;
        logic [2:0] p;

        // Reset, then default pattern 110.
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Load 101 and stream 1,0,1,0,1: overlap vs non-overlap.
        cyc(1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Bubble transparency on pattern 110.
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        bit_in(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        bit_in(1'b1); bit_in(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Reset mid-pattern drops history.
        bit_in(1'b1); bit_in(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
        bit_in(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Pattern 111 on six ones: consecutive matches, narrow counter saturates.
        cyc(1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 6; i++) bit_in(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        bit_in(1'b1);

        // Load wins over a simultaneous sample.
        bit_in(1'b1); bit_in(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 3'b011, 1'b0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            p = 3'($urandom);
            cyc(e, d, l, p, r);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
`default_nettype wire
